// File: rtl/lc3_mem_model.sv
// LC3 unified memory model: one word array shared by a fetch port and a data port,
// each with its own fixed-latency request/complete handshake, plus a bench preload port.
module lc3_mem_model #(
  parameter logic [15:0] BASE_ADDR = 16'h3000,
  parameter int unsigned AW        = 10,
  parameter int unsigned LAT_I     = 1,
  parameter int unsigned LAT_D     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        data_req,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic [15:0] instr_cnt,
  output logic [15:0] data_cnt
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 16;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [DW-1:0] CNT_MAX = 16'hFFFF;

  // A latency of 0 is treated as 1, so the reload value never goes negative.
  localparam logic [CW-1:0] LAT_I_M1 = (LAT_I > 1) ? CW'(LAT_I - 1) : '0;
  localparam logic [CW-1:0] LAT_D_M1 = (LAT_D > 1) ? CW'(LAT_D - 1) : '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Offset from BASE_ADDR with 16-bit wrap, folded into the array.
  function automatic logic [AW-1:0] to_idx(input logic [15:0] a);
    return AW'(a - BASE_ADDR);
  endfunction

  logic [DW-1:0] mem_q [DEPTH];

  state_e        ist_q, ist_d;
  logic [CW-1:0] ilat_q, ilat_d;
  logic [AW-1:0] iidx_q, iidx_d;
  logic          ifire_c;
  logic [DW-1:0] instr_dout_q;
  logic          complete_instr_q;
  logic [DW-1:0] instr_cnt_q;

  state_e        dst_q, dst_d;
  logic [CW-1:0] dlat_q, dlat_d;
  logic [AW-1:0] didx_q, didx_d;
  logic          drd_q, drd_d;
  logic [DW-1:0] ddin_q, ddin_d;
  logic          dfire_c;
  logic [DW-1:0] data_dout_q;
  logic          complete_data_q;
  logic [DW-1:0] data_cnt_q;

  // Fetch path next state
  always_comb begin
    ist_d   = ist_q;
    ilat_d  = ilat_q;
    iidx_d  = iidx_q;
    ifire_c = 1'b0;
    if (reset) begin
      ist_d = S_IDLE;
    end else begin
      case (ist_q)
        S_IDLE: begin
          if (instrmem_rd) begin
            ist_d  = S_WAIT;
            ilat_d = LAT_I_M1;
            iidx_d = to_idx(pc);
          end
        end
        S_WAIT: begin
          if (!instrmem_rd) begin
            ist_d = S_IDLE;
          end else if (ilat_q == '0) begin
            ifire_c = 1'b1;
            ist_d   = S_IDLE;
          end else begin
            ilat_d = ilat_q - CW'(1);
          end
        end
        default: ist_d = S_IDLE;
      endcase
    end
  end

  // Data path next state; a dropped request in WAIT aborts without side effects
  always_comb begin
    dst_d   = dst_q;
    dlat_d  = dlat_q;
    didx_d  = didx_q;
    drd_d   = drd_q;
    ddin_d  = ddin_q;
    dfire_c = 1'b0;
    if (reset) begin
      dst_d = S_IDLE;
    end else begin
      case (dst_q)
        S_IDLE: begin
          if (data_req) begin
            dst_d  = S_WAIT;
            dlat_d = LAT_D_M1;
            didx_d = to_idx(Data_addr);
            drd_d  = Data_rd;
            ddin_d = Data_din;
          end
        end
        S_WAIT: begin
          if (!data_req) begin
            dst_d = S_IDLE;
          end else if (dlat_q == '0) begin
            dfire_c = 1'b1;
            dst_d   = S_IDLE;
          end else begin
            dlat_d = dlat_q - CW'(1);
          end
        end
        default: dst_d = S_IDLE;
      endcase
    end
  end

  // Fetch path registers and outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      ist_q            <= S_IDLE;
      ilat_q           <= '0;
      iidx_q           <= '0;
      instr_dout_q     <= '0;
      complete_instr_q <= 1'b0;
      instr_cnt_q      <= '0;
    end else begin
      ist_q            <= ist_d;
      ilat_q           <= ilat_d;
      iidx_q           <= iidx_d;
      complete_instr_q <= ifire_c;
      if (ifire_c) begin
        instr_dout_q <= mem_q[iidx_q];
        if (instr_cnt_q != CNT_MAX) begin
          instr_cnt_q <= instr_cnt_q + DW'(1);
        end
      end
    end
  end

  // Data path registers and outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      dst_q           <= S_IDLE;
      dlat_q          <= '0;
      didx_q          <= '0;
      drd_q           <= 1'b0;
      ddin_q          <= '0;
      data_dout_q     <= '0;
      complete_data_q <= 1'b0;
      data_cnt_q      <= '0;
    end else begin
      dst_q           <= dst_d;
      dlat_q          <= dlat_d;
      didx_q          <= didx_d;
      drd_q           <= drd_d;
      ddin_q          <= ddin_d;
      complete_data_q <= dfire_c;
      if (dfire_c) begin
        if (drd_q) begin
          data_dout_q <= mem_q[didx_q];
        end
        if (data_cnt_q != CNT_MAX) begin
          data_cnt_q <= data_cnt_q + DW'(1);
        end
      end
    end
  end

  // Array: no reset; reads above see the pre-edge word, and preload is last so it wins
  always_ff @(posedge clock) begin
    if (dfire_c && !drd_q) begin
      mem_q[didx_q] <= ddin_q;
    end
    if (load_en) begin
      mem_q[to_idx(load_addr)] <= load_data;
    end
  end

  assign Instr_dout     = instr_dout_q;
  assign complete_instr = complete_instr_q;
  assign instr_cnt      = instr_cnt_q;
  assign Data_dout      = data_dout_q;
  assign complete_data  = complete_data_q;
  assign data_cnt       = data_cnt_q;

endmodule

// File: tb/tb_lc3_mem_model.sv
// Directed bench for lc3_mem_model: default instance plus a LAT_I=0 / LAT_D=3 instance on shared stimulus.
module tb_lc3_mem_model;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic        data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  logic [15:0] Instr_dout, Data_dout, instr_cnt, data_cnt;
  logic        complete_instr, complete_data;
  logic [15:0] Instr_dout3, Data_dout3, instr_cnt3, data_cnt3;
  logic        complete_instr3, complete_data3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  lc3_mem_model u_dut (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(Data_dout), .complete_data(complete_data),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr_cnt(instr_cnt), .data_cnt(data_cnt)
  );

  lc3_mem_model #(.LAT_I(0), .LAT_D(3)) u_dut3 (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout3), .complete_instr(complete_instr3),
    .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(Data_dout3), .complete_data(complete_data3),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr_cnt(instr_cnt3), .data_cnt(data_cnt3)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; both instances complete one edge after the accepting edge.
  task automatic fetch(input logic [15:0] a, input logic [15:0] exp, input logic [15:0] exp3,
                       input logic [15:0] cnt);
    pc          = a;
    instrmem_rd = 1'b1;
    @(negedge clock);
    chk("fetch_early", 16'(complete_instr), 16'd0);
    @(negedge clock);
    chk("fetch_done", 16'(complete_instr), 16'd1);
    chk("fetch_dout", Instr_dout, exp);
    chk("fetch_cnt", instr_cnt, cnt);
    chk("fetch_done3", 16'(complete_instr3), 16'd1);
    chk("fetch_dout3", Instr_dout3, exp3);
    chk("fetch_cnt3", instr_cnt3, cnt);
    instrmem_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc = '0; instrmem_rd = 1'b0;
    data_req = 1'b0; Data_rd = 1'b0; Data_addr = '0; Data_din = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_instr_dout", Instr_dout, 16'h0000);
    chk("rst_data_dout", Data_dout, 16'h0000);
    chk("rst_ci", 16'(complete_instr), 16'd0);
    chk("rst_cd", 16'(complete_data), 16'd0);
    chk("rst_icnt", instr_cnt, 16'd0);
    chk("rst_dcnt", data_cnt, 16'd0);
    reset = 1'b0;

    // Preload
    load_en = 1'b1; load_addr = 16'h3000; load_data = 16'h1021;
    @(negedge clock);
    load_addr = 16'h3005; load_data = 16'hABCD;
    @(negedge clock);
    load_en = 1'b0;

    // Basic fetch, then output holds after the pulse
    fetch(16'h3000, 16'h1021, 16'h1021, 16'd1);
    @(negedge clock);
    chk("fetch_pulse_end", 16'(complete_instr), 16'd0);
    chk("fetch_hold", Instr_dout, 16'h1021);

    // Write BEEF then back-to-back read of 16'h3010
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3010; Data_din = 16'hBEEF;
    @(negedge clock);
    chk("wr_lat1", 16'(complete_data), 16'd0);
    @(negedge clock);
    chk("wr_lat2", 16'(complete_data), 16'd0);
    @(negedge clock);
    chk("wr_done", 16'(complete_data), 16'd1);
    chk("wr_dout_unchanged", Data_dout, 16'h0000);
    chk("wr_cnt", data_cnt, 16'd1);
    Data_rd = 1'b1;
    @(negedge clock);
    chk("rd_lat1", 16'(complete_data), 16'd0);
    @(negedge clock);
    chk("rd_lat2", 16'(complete_data), 16'd0);
    @(negedge clock);
    chk("rd_done", 16'(complete_data), 16'd1);
    chk("rd_dout", Data_dout, 16'hBEEF);
    chk("rd_cnt", data_cnt, 16'd2);
    data_req = 1'b0;

    // Abort: drop the request one cycle after accept
    @(negedge clock);
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3005; Data_din = 16'hDEAD;
    @(negedge clock);
    data_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_cd", 16'(complete_data), 16'd0);
      chk("abort_cd3", 16'(complete_data3), 16'd0);
    end
    chk("abort_cnt", data_cnt, 16'd2);
    chk("abort_cnt3", data_cnt3, 16'd1);
    fetch(16'h3005, 16'hABCD, 16'hABCD, 16'd2);

    // Fetch and data write to the same word on the same edge: fetch sees the old word
    @(negedge clock);
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3010; Data_din = 16'h1234;
    @(negedge clock);
    pc = 16'h3010; instrmem_rd = 1'b1;
    @(negedge clock);
    chk("same_ci_early", 16'(complete_instr), 16'd0);
    chk("same_cd_early", 16'(complete_data), 16'd0);
    @(negedge clock);
    chk("same_ci", 16'(complete_instr), 16'd1);
    chk("same_cd", 16'(complete_data), 16'd1);
    chk("same_old_word", Instr_dout, 16'hBEEF);
    chk("same_dcnt", data_cnt, 16'd3);
    data_req = 1'b0; instrmem_rd = 1'b0;
    @(negedge clock);
    fetch(16'h3010, 16'h1234, 16'hBEEF, 16'd4);

    // Reset mid-WAIT of a write to 16'h3000; requests ignored while in reset
    @(negedge clock);
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3000; Data_din = 16'h5555;
    @(negedge clock);
    reset = 1'b1; pc = 16'h3000; instrmem_rd = 1'b1;
    @(negedge clock);
    chk("mid_rst_ci", 16'(complete_instr), 16'd0);
    chk("mid_rst_cd", 16'(complete_data), 16'd0);
    chk("mid_rst_idout", Instr_dout, 16'h0000);
    chk("mid_rst_ddout", Data_dout, 16'h0000);
    chk("mid_rst_icnt", instr_cnt, 16'd0);
    chk("mid_rst_dcnt", data_cnt, 16'd0);
    @(negedge clock);
    chk("mid_rst_ci2", 16'(complete_instr), 16'd0);
    chk("mid_rst_cd2", 16'(complete_data), 16'd0);
    reset = 1'b0; data_req = 1'b0; instrmem_rd = 1'b0;
    @(negedge clock);
    chk("post_rst_cd", 16'(complete_data), 16'd0);
    fetch(16'h3000, 16'h1021, 16'h1021, 16'd1);

    // Address wrap-around and aliasing below BASE_ADDR
    @(negedge clock);
    fetch(16'h3400, 16'h1021, 16'h1021, 16'd2);
    @(negedge clock);
    fetch(16'h2C05, 16'hABCD, 16'hABCD, 16'd3);
    chk("final_dcnt", data_cnt, 16'd0);

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
